// File: rtl/result_checker.sv
// result_checker: multi-channel probe capture and in-order answer scoreboard.
// Optional define RESULT_CHECKER_LOG_EN adds simulation-only comparison logging.
module result_checker #(
   parameter int XLEN           = 32,
   parameter int CHANNELS       = 2,
   parameter int ANS_DEPTH      = 768,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   localparam int AW            = $clog2(ANS_DEPTH)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [AW:0]              ans_count,
   input  logic                     ans_we,
   input  logic [AW-1:0]            ans_addr,
   input  logic [XLEN-1:0]          ans_wdata,
   input  logic [CHANNELS*XLEN-1:0] probe_pc,
   input  logic [CHANNELS*XLEN-1:0] probe_data,
   input  logic [CHANNELS*XLEN-1:0] trig_pc,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic                     all_pass,
   output logic [AW:0]              pass_cnt,
   output logic [AW:0]              fail_cnt,
   output logic                     overflow,
   output logic [AW-1:0]            first_fail_idx,
   output logic [XLEN-1:0]          first_fail_exp,
   output logic [XLEN-1:0]          first_fail_got
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;
   localparam logic [31:0] TO_W = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_TMO  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0] ans_q  [ANS_DEPTH];
   logic [XLEN-1:0] fifo_q [FIFO_DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [AW:0]     idx_q, idx_d;
   logic [AW:0]     cnt_lat_q, cnt_lat_d;
   logic [AW:0]     pass_q, pass_d;
   logic [AW:0]     fail_q, fail_d;
   logic            ovf_q, ovf_d;
   logic            ffv_q, ffv_d;
   logic [AW-1:0]   ff_idx_q, ff_idx_d;
   logic [XLEN-1:0] ff_exp_q, ff_exp_d;
   logic [XLEN-1:0] ff_got_q, ff_got_d;
   logic [31:0]     cyc_q, cyc_d;

   logic                run;
   logic                start_ok;
   logic                pop;
   logic                match;
   logic [XLEN-1:0]     exp_val;
   logic [XLEN-1:0]     got_val;
   logic [CHANNELS-1:0] hit;
   logic [CHANNELS-1:0] push_en;
   logic [PW-1:0]       push_slot [CHANNELS];
   logic [FW-1:0]       free;
   logic [FW-1:0]       n_push;
   logic                drop;

   assign run      = (state_q == S_RUN);
   assign start_ok = start && !run;
   assign pop      = run && (fcnt_q != '0);
   assign exp_val  = ans_q[idx_q[AW-1:0]];
   assign got_val  = fifo_q[rd_ptr_q];
   assign match    = (exp_val == got_val);

   assign busy           = run;
   assign done           = (state_q == S_DONE);
   assign timeout        = (state_q == S_TMO);
   assign all_pass       = done && (fail_q == '0) && !ovf_q;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign overflow       = ovf_q;
   assign first_fail_idx = ff_idx_q;
   assign first_fail_exp = ff_exp_q;
   assign first_fail_got = ff_got_q;

   // Per-channel trigger match on exact PC equality.
   always_comb begin
      hit = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         hit[k] = (probe_pc[k*XLEN +: XLEN] == trig_pc[k*XLEN +: XLEN]);
      end
   end

   // Give free FIFO slots to hitting channels, lowest channel first.
   always_comb begin
      free   = FW'(FIFO_DEPTH) - fcnt_q + FW'(pop);
      n_push = '0;
      drop   = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         push_en[k]   = 1'b0;
         push_slot[k] = '0;
         if (run && hit[k]) begin
            if (n_push < free) begin
               push_en[k]   = 1'b1;
               push_slot[k] = wr_ptr_q + n_push[PW-1:0];
               n_push       = n_push + FW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   // Scoreboard datapath: pointers, compare, counters, first-failure capture.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + n_push[PW-1:0];
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      fcnt_d    = fcnt_q + n_push - FW'(pop);
      idx_d     = idx_q;
      cnt_lat_d = cnt_lat_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      ovf_d     = ovf_q | drop;
      ffv_d     = ffv_q;
      ff_idx_d  = ff_idx_q;
      ff_exp_d  = ff_exp_q;
      ff_got_d  = ff_got_q;
      cyc_d     = cyc_q;
      if (run) begin
         cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
      end
      if (pop) begin
         idx_d = idx_q + (AW+1)'(1);
         if (match) begin
            pass_d = (pass_q == '1) ? pass_q : pass_q + (AW+1)'(1);
         end else begin
            fail_d = (fail_q == '1) ? fail_q : fail_q + (AW+1)'(1);
            if (!ffv_q) begin
               ffv_d    = 1'b1;
               ff_idx_d = idx_q[AW-1:0];
               ff_exp_d = exp_val;
               ff_got_d = got_val;
            end
         end
      end
      if (start_ok) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         fcnt_d    = '0;
         idx_d     = '0;
         cnt_lat_d = ans_count;
         pass_d    = '0;
         fail_d    = '0;
         ovf_d     = 1'b0;
         ffv_d     = 1'b0;
         ff_idx_d  = '0;
         ff_exp_d  = '0;
         ff_got_d  = '0;
         cyc_d     = '0;
      end
   end

   // Run control: completion beats watchdog on the same edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (idx_d == cnt_lat_q) begin
               state_d = S_DONE;
            end else if (TIMEOUT_CYCLES != 0 && cyc_d == TO_W) begin
               state_d = S_TMO;
            end
         end
         S_DONE: if (start) state_d = S_RUN;
         S_TMO:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // State and scoreboard registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         idx_q     <= '0;
         cnt_lat_q <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         ovf_q     <= 1'b0;
         ffv_q     <= 1'b0;
         ff_idx_q  <= '0;
         ff_exp_q  <= '0;
         ff_got_q  <= '0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fcnt_q    <= fcnt_d;
         idx_q     <= idx_d;
         cnt_lat_q <= cnt_lat_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         ovf_q     <= ovf_d;
         ffv_q     <= ffv_d;
         ff_idx_q  <= ff_idx_d;
         ff_exp_q  <= ff_exp_d;
         ff_got_q  <= ff_got_d;
         cyc_q     <= cyc_d;
      end
   end

   // Answer table: no reset so contents survive a mid-run reset.
   always_ff @(posedge clock) begin
      if (ans_we && !run) begin
         ans_q[ans_addr] <= ans_wdata;
      end
   end

   // Capture FIFO storage.
   always_ff @(posedge clock) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (push_en[k]) begin
            fifo_q[push_slot[k]] <= probe_data[k*XLEN +: XLEN];
         end
      end
   end

`ifdef RESULT_CHECKER_LOG_EN
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CW-1:0] chan_q [FIFO_DEPTH];

   // Channel tag per FIFO slot, only needed for the log.
   always_ff @(posedge clock) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (push_en[k]) begin
            chan_q[push_slot[k]] <= CW'(k);
         end
      end
   end

   // Per-comparison and end-of-run log lines.
   always @(posedge clock) begin
      if (reset_n && pop) begin
         $display("result_checker: ch%0d idx=%0d exp=%h got=%h %s",
                  chan_q[rd_ptr_q], idx_q, exp_val, got_val,
                  match ? "correct!" : "wrong!");
      end
      if (reset_n && run && state_d != S_RUN) begin
         $display("result_checker: %s pass=%0d fail=%0d ovf=%0d",
                  (state_d == S_DONE) ? "DONE" : "TIMEOUT",
                  pass_d, fail_d, ovf_d);
      end
   end
`endif

endmodule

// File: tb/tb_result_checker.sv
// Directed self-checking bench for result_checker.
// Small FIFO and short watchdog expose the boundary behaviour.
module tb_result_checker;

   localparam int XLEN = 32;
   localparam int CH   = 2;
   localparam int AW   = 10;

   logic              clock;
   logic              reset_n;
   logic              start;
   logic [AW:0]       ans_count;
   logic              ans_we;
   logic [AW-1:0]     ans_addr;
   logic [XLEN-1:0]   ans_wdata;
   logic [CH*XLEN-1:0] probe_pc;
   logic [CH*XLEN-1:0] probe_data;
   logic [CH*XLEN-1:0] trig_pc;
   logic              busy;
   logic              done;
   logic              timeout;
   logic              all_pass;
   logic [AW:0]       pass_cnt;
   logic [AW:0]       fail_cnt;
   logic              overflow;
   logic [AW-1:0]     first_fail_idx;
   logic [XLEN-1:0]   first_fail_exp;
   logic [XLEN-1:0]   first_fail_got;

   int checks   = 0;
   int failures = 0;

   result_checker #(
      .XLEN(XLEN),
      .CHANNELS(CH),
      .ANS_DEPTH(768),
      .FIFO_DEPTH(2),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .ans_count(ans_count),
      .ans_we(ans_we),
      .ans_addr(ans_addr),
      .ans_wdata(ans_wdata),
      .probe_pc(probe_pc),
      .probe_data(probe_data),
      .trig_pc(trig_pc),
      .busy(busy),
      .done(done),
      .timeout(timeout),
      .all_pass(all_pass),
      .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt),
      .overflow(overflow),
      .first_fail_idx(first_fail_idx),
      .first_fail_exp(first_fail_exp),
      .first_fail_got(first_fail_got)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input bit e0, input logic [31:0] d0,
                      input bit e1, input logic [31:0] d1);
      probe_pc   = {e1 ? 32'h200 : 32'h0, e0 ? 32'h100 : 32'h0};
      probe_data = {d1, d0};
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      ans_we    = 1'b1;
      ans_addr  = AW'(a);
      ans_wdata = d;
      step();
      ans_we = 1'b0;
   endtask

   task automatic go(input int n);
      ans_count = (AW+1)'(n);
      start     = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      ans_count = '0;
      ans_we    = 1'b0;
      ans_addr  = '0;
      ans_wdata = '0;
      trig_pc   = {32'h200, 32'h100};
      drv(0, 0, 0, 0);
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tmo", timeout, 0);
      check("rst_allpass", all_pass, 0);
      check("rst_pass", pass_cnt, 0);
      check("rst_fail", fail_cnt, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ffgot", first_fail_got, 0);
      reset_n = 1'b1;
      step();

      // basic pass run: 1,1,2
      wr(0, 1);
      wr(1, 1);
      wr(2, 2);
      go(3);
      check("t1_busy", busy, 1);
      drv(1, 1, 0, 0);
      step();
      check("t1_lat0", pass_cnt, 0);
      drv(1, 1, 0, 0);
      step();
      check("t1_lat1", pass_cnt, 1);
      drv(1, 2, 0, 0);
      step();
      drv(0, 0, 0, 0);
      step();
      check("t1_pass", pass_cnt, 3);
      check("t1_fail", fail_cnt, 0);
      check("t1_done", done, 1);
      check("t1_allpass", all_pass, 1);
      check("t1_busy0", busy, 0);

      // one mismatch; a start pulse in RUN must be ignored
      go(3);
      drv(1, 1, 0, 0);
      step();
      drv(1, 5, 0, 0);
      step();
      drv(1, 2, 0, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      drv(0, 0, 0, 0);
      step();
      check("t2_done", done, 1);
      check("t2_pass", pass_cnt, 2);
      check("t2_fail", fail_cnt, 1);
      check("t2_ffidx", first_fail_idx, 1);
      check("t2_ffexp", first_fail_exp, 1);
      check("t2_ffgot", first_fail_got, 5);
      check("t2_allpass", all_pass, 0);

      // same-cycle hits compared ch0 then ch1
      wr(0, 32'hDEADBEEF);
      wr(1, 32'h12345678);
      go(2);
      drv(1, 32'hDEADBEEF, 1, 32'h12345678);
      step();
      drv(0, 0, 0, 0);
      step();
      check("t3_mid", pass_cnt, 1);
      step();
      check("t3_pass", pass_cnt, 2);
      check("t3_fail", fail_cnt, 0);
      check("t3_allpass", all_pass, 1);

      // overflow with a 2-entry FIFO; table write in RUN ignored
      wr(0, 7);
      wr(1, 7);
      wr(2, 7);
      wr(3, 7);
      go(4);
      ans_we    = 1'b1;
      ans_addr  = 3;
      ans_wdata = 9;
      drv(1, 7, 1, 7);
      step();
      check("t4_ovf0", overflow, 0);
      step();
      check("t4_ovf1", overflow, 1);
      step();
      check("t4_pass2", pass_cnt, 2);
      ans_we = 1'b0;
      drv(0, 0, 0, 0);
      step();
      check("t4_busy", busy, 1);
      step();
      check("t4_done", done, 1);
      check("t4_pass", pass_cnt, 4);
      check("t4_fail", fail_cnt, 0);
      check("t4_ovf", overflow, 1);
      check("t4_allpass", all_pass, 0);

      // zero-length run
      go(0);
      check("t0_busy", busy, 1);
      check("t0_ovfclr", overflow, 0);
      step();
      check("t0_done", done, 1);
      check("t0_allpass", all_pass, 1);

      // watchdog after 50 RUN cycles
      go(2);
      drv(1, 3, 0, 0);
      step();
      drv(0, 0, 0, 0);
      step();
      check("t5_fail", fail_cnt, 1);
      check("t5_ffgot", first_fail_got, 3);
      repeat (47) step();
      check("t5_busy49", busy, 1);
      check("t5_tmo49", timeout, 0);
      step();
      check("t5_tmo", timeout, 1);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      go(3);
      check("t5_rerun", busy, 1);
      check("t5_failclr", fail_cnt, 0);
      check("t5_ffclr", first_fail_got, 0);

      // reset mid-run after two passes
      drv(1, 7, 0, 0);
      step();
      step();
      drv(0, 0, 0, 0);
      step();
      check("t6_pass2", pass_cnt, 2);
      reset_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_pass", pass_cnt, 0);
      check("t6_done", done, 0);
      step();
      reset_n = 1'b1;
      step();
      go(3);
      drv(1, 7, 0, 0);
      step();
      step();
      step();
      drv(0, 0, 0, 0);
      step();
      check("t6_done2", done, 1);
      check("t6_pass3", pass_cnt, 3);
      check("t6_allpass", all_pass, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_checker.md
# result_checker

Parametrised, synthesizable successor to the single-probe bench checker in the test driver. It watches up to CHANNELS core probe points, captures a data value whenever a probe's PC matches that channel's trigger PC, and compares captured values in order against an expected-answer table. It reports pass/fail counts, first-failure details and a done/timeout verdict, so the same scoreboard runs in simulation and on FPGA beside the tile.

## Interface
- XLEN, 32, probe PC and data width.
- CHANNELS, 2, number of independent probe ports.
- ANS_DEPTH, 768, expected-answer table entries; index width AW = $clog2(ANS_DEPTH).
- FIFO_DEPTH, 8, capture FIFO entries; power of two, at least CHANNELS.
- TIMEOUT_CYCLES, 1000, maximum RUN cycles before timeout; 0 disables the watchdog.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE, DONE or TMO.
- ans_count  in  AW+1  number of expected results; sampled on start.
- ans_we  in  1  answer-table write strobe; ignored in RUN.
- ans_addr  in  AW  answer-table write index.
- ans_wdata  in  XLEN  answer-table write data.
- probe_pc  in  CHANNELS*XLEN  per-channel PC; channel k occupies bits [k*XLEN +: XLEN].
- probe_data  in  CHANNELS*XLEN  per-channel value to check.
- trig_pc  in  CHANNELS*XLEN  per-channel trigger PC.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in TMO.
- all_pass  out  1  done && fail_cnt==0 && !overflow.
- pass_cnt  out  AW+1  matching comparisons.
- fail_cnt  out  AW+1  mismatching comparisons.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.
- first_fail_idx  out  AW  answer index of the first mismatch.
- first_fail_exp  out  XLEN  expected value at the first mismatch.
- first_fail_got  out  XLEN  captured value at the first mismatch.

## Operation
- States: IDLE, RUN, DONE, TMO.
  - IDLE -> RUN on start.
  - RUN -> DONE when the comparison index reaches the ans_count latched at start.
  - RUN -> TMO when the cycle counter reaches TIMEOUT_CYCLES first.
  - DONE/TMO -> RUN on start.
  - start in RUN is ignored.
- start clears the counters, overflow, first_fail_* and FIFO pointers, and latches ans_count.
- ans_count==0: start goes RUN for one cycle, then DONE with all_pass=1.
- Capture, RUN only:
  - Channel k hits when probe_pc[k]==trig_pc[k].
  - All hits in one cycle are pushed in ascending channel order into consecutive FIFO slots.
  - Hits that do not fit are dropped and set overflow; lower channels take priority for free slots.
- Compare: at most one FIFO pop per cycle in RUN. The popped value is compared with ans[idx], then idx increments.
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments. On the first mismatch of the run, first_fail_idx/exp/got are loaded and then held.
- Entries left in the FIFO at DONE are discarded. Hits outside RUN are ignored.
- Counters saturate at all-ones.
- All comparisons are exact XLEN-bit equality.

## Timing
- Reset values: state IDLE; all outputs 0; FIFO empty; cycle counter 0.
- Reset may be asserted mid-run. It forces IDLE immediately and preserves the answer table contents (the table has no reset).
- Latency: a hit sampled at edge t with an empty FIFO updates the counters at edge t+1.
- Throughput: one comparison per cycle. Sustained multi-channel hits fill the FIFO.
- FIFO boundaries:
  - Full with a simultaneous pop: one push slot is available.
  - Pointers wrap modulo FIFO_DEPTH.
- Answer-table writes take effect at the write edge. A write to index i in the same cycle as a compare of index i is ignored (RUN blocks writes).
- The cycle counter counts RUN cycles starting from the cycle after start. TMO is entered at the edge where the count equals TIMEOUT_CYCLES. If that is the same edge as the final compare, DONE wins.

## Configuration
- RESULT_CHECKER_LOG_EN
  - Defined: simulation-only $display on every comparison with the channel, index, expected and captured values, plus "correct!"/"wrong!". A summary line is printed on entering DONE or TMO.
  - Undefined: no system tasks are present and the block is fully synthesizable. Logic behaviour is identical either way.

## Test plan
- Load ans[0..2]=1,1,2 and ans_count=3, then start. Channel 0 hits with data 1,1,2 on separate cycles -> pass_cnt=3, fail_cnt=0, done=1, all_pass=1.
- Same table, with the second capture returning 0x5 -> fail_cnt=1, first_fail_idx=1, first_fail_exp=1, first_fail_got=5, all_pass=0.
- Both channels hit in the same cycle with data A (ch0) and B (ch1), ans={A,B} -> compared in order ch0 then ch1, pass_cnt=2.
- FIFO_DEPTH=2 and CHANNELS=2, with both channels hitting for 3 consecutive cycles -> overflow=1 and at least one entry dropped, all_pass=0 at done.
- TIMEOUT_CYCLES=50 with no hits -> timeout=1 at RUN cycle 50, busy=0; then start -> RUN with counters cleared.
- Deassert reset_n mid-run after 2 passes -> all outputs 0 and IDLE immediately. The next start with the answer table unchanged completes correctly.
